// File: rtl/sdram_burst_sched.sv
// Burst scheduler for the SDRAM circular word buffer: picks write/read bursts from FIFO
// levels, owns the write/read pointers and buffer fill level, one command per ack handshake.
module sdram_burst_sched #(
  parameter int unsigned ADDR_W        = 22,
  parameter int unsigned BURST_LEN     = 4,
  parameter int unsigned WCNT_W        = 9,
  parameter int unsigned RCNT_W        = 9,
  parameter int unsigned RD_FIFO_DEPTH = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sdram_init_done,
  input  logic [WCNT_W-1:0] i_wr_fifo_cnt,
  input  logic [RCNT_W-1:0] i_rd_fifo_cnt,
  input  logic              i_rd_en,
  input  logic              i_cmd_ack,
  output logic [1:0]        o_ctrl_cmd,
  output logic [ADDR_W-1:0] o_sys_addr,
  output logic [ADDR_W:0]   o_buf_level,
  output logic              o_buf_full,
  output logic              o_buf_empty,
  output logic              o_busy
);

  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0]  BL_LVL   = LVL_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BL_ADDR  = ADDR_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  FULL_THR = LVL_W'((64'd1 << ADDR_W) - 64'(BURST_LEN));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b10;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_last_wr;
  logic              r_init_done;
  logic [WCNT_W-1:0] r_wr_cnt;
  logic [RCNT_W-1:0] r_rd_cnt;
  logic              r_rd_en;

  logic [1:0]        w_state_nxt;
  logic [1:0]        w_cmd_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;
  logic [LVL_W-1:0]  w_level_nxt;
  logic              w_last_wr_nxt;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // Eligibility works on the registered copies of the FIFO status inputs.
  always_comb begin
    w_wr_ok = r_init_done && (32'(r_wr_cnt) >= BURST_LEN) && !o_buf_full;
    w_rd_ok = r_init_done && r_rd_en && !o_buf_empty &&
              ((32'(r_rd_cnt) + BURST_LEN) <= RD_FIFO_DEPTH);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_nxt     = o_ctrl_cmd;
    w_addr_nxt    = o_sys_addr;
    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_level_nxt   = o_buf_level;
    w_last_wr_nxt = r_last_wr;
    case (r_state)
      S_IDLE: begin
        // When both are eligible, go opposite to the last completed op.
        if (w_wr_ok && (!w_rd_ok || !r_last_wr)) begin
          w_state_nxt = S_WR;
          w_cmd_nxt   = CMD_WR;
          w_addr_nxt  = r_wr_ptr;
        end else if (w_rd_ok) begin
          w_state_nxt = S_RD;
          w_cmd_nxt   = CMD_RD;
          w_addr_nxt  = r_rd_ptr;
        end
      end
      S_WR: begin
        if (i_cmd_ack) begin
          w_state_nxt   = S_IDLE;
          w_cmd_nxt     = CMD_IDLE;
          w_wr_ptr_nxt  = r_wr_ptr + BL_ADDR;
          w_level_nxt   = o_buf_level + BL_LVL;
          w_last_wr_nxt = 1'b1;
        end
      end
      S_RD: begin
        if (i_cmd_ack) begin
          w_state_nxt   = S_IDLE;
          w_cmd_nxt     = CMD_IDLE;
          w_rd_ptr_nxt  = r_rd_ptr + BL_ADDR;
          w_level_nxt   = o_buf_level - BL_LVL;
          w_last_wr_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cmd_nxt   = CMD_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      o_ctrl_cmd  <= CMD_IDLE;
      o_sys_addr  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      o_buf_level <= '0;
      r_last_wr   <= 1'b0;
      o_buf_full  <= 1'b0;
      o_buf_empty <= 1'b1;
      o_busy      <= 1'b0;
      r_init_done <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_rd_en     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      o_ctrl_cmd  <= w_cmd_nxt;
      o_sys_addr  <= w_addr_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      o_buf_level <= w_level_nxt;
      r_last_wr   <= w_last_wr_nxt;
      o_buf_full  <= (w_level_nxt > FULL_THR);
      o_buf_empty <= (w_level_nxt < BL_LVL);
      o_busy      <= (w_state_nxt != S_IDLE);
      r_init_done <= i_sdram_init_done;
      r_wr_cnt    <= i_wr_fifo_cnt;
      r_rd_cnt    <= i_rd_fifo_cnt;
      r_rd_en     <= i_rd_en;
    end
  end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Bench for sdram_burst_sched: directed scenarios plus randomized traffic against a
// transaction-level model of the circular buffer (small ADDR_W so wrap and full are reached).
module tb_sdram_burst_sched;

  localparam int AW    = 6;
  localparam int BL    = 4;
  localparam int DEPTH = 256;
  localparam int SIZE  = 1 << AW;

  logic          clk;
  logic          rst;
  logic          init;
  logic [8:0]    wcnt;
  logic [8:0]    rcnt;
  logic          rd_en;
  logic          ack;
  logic [1:0]    ctrl_cmd;
  logic [AW-1:0] sys_addr;
  logic [AW:0]   buf_level;
  logic          buf_full;
  logic          buf_empty;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model: outstanding command plus buffer bookkeeping
  int m_pend, m_cmd, m_addr, m_wp, m_rp, m_level;
  bit m_last_wr;
  int d_init, d_wcnt, d_rcnt, d_rden;
  int ack_wait;

  sdram_burst_sched #(
    .ADDR_W(AW), .BURST_LEN(BL), .WCNT_W(9), .RCNT_W(9), .RD_FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sdram_init_done(init),
    .i_wr_fifo_cnt(wcnt), .i_rd_fifo_cnt(rcnt), .i_rd_en(rd_en), .i_cmd_ack(ack),
    .o_ctrl_cmd(ctrl_cmd), .o_sys_addr(sys_addr), .o_buf_level(buf_level),
    .o_buf_full(buf_full), .o_buf_empty(buf_empty), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit wr_ok, rd_ok, go_wr;
    if (rst) begin
      m_pend = 0; m_cmd = 0; m_addr = 0; m_wp = 0; m_rp = 0; m_level = 0;
      m_last_wr = 0; d_init = 0; d_wcnt = 0; d_rcnt = 0; d_rden = 0;
    end else begin
      if (m_pend == 0) begin
        wr_ok = (d_init != 0) && (d_wcnt >= BL) && (m_level <= SIZE - BL);
        rd_ok = (d_init != 0) && (d_rden != 0) && (m_level >= BL) && (DEPTH - d_rcnt >= BL);
        go_wr = (wr_ok && rd_ok) ? !m_last_wr : wr_ok;
        if (go_wr) begin
          m_pend = 1; m_cmd = 1; m_addr = m_wp;
        end else if (rd_ok) begin
          m_pend = 2; m_cmd = 2; m_addr = m_rp;
        end
      end else if (ack) begin
        if (m_pend == 1) begin
          m_wp = (m_wp + BL) % SIZE; m_level += BL; m_last_wr = 1;
        end else begin
          m_rp = (m_rp + BL) % SIZE; m_level -= BL; m_last_wr = 0;
        end
        m_pend = 0; m_cmd = 0;
      end
      d_init = int'(init); d_wcnt = int'(wcnt); d_rcnt = int'(rcnt); d_rden = int'(rd_en);
    end
  endtask

  task automatic compare();
    chk("ctrl_cmd", int'(ctrl_cmd), m_cmd);
    chk("sys_addr", int'(sys_addr), m_addr);
    chk("buf_level", int'(buf_level), m_level);
    chk("buf_full", int'(buf_full), int'(m_level > SIZE - BL));
    chk("buf_empty", int'(buf_empty), int'(m_level < BL));
    chk("busy", int'(busy), int'(m_pend != 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare();
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; wcnt = '0; rcnt = '0; rd_en = 1'b0; ack = 1'b0;
    ack_wait = 0;
    m_pend = 0; m_cmd = 0; m_addr = 0; m_wp = 0; m_rp = 0; m_level = 0; m_last_wr = 0;
    d_init = 0; d_wcnt = 0; d_rcnt = 0; d_rden = 0;
    @(negedge clk);
    tick();
    chk("reset_cmd", int'(ctrl_cmd), 0);
    chk("reset_empty", int'(buf_empty), 1);

    // single write burst, held until ack
    rst = 1'b0; init = 1'b1; wcnt = 9'd4;
    tick();
    chk("wr_not_yet", int'(ctrl_cmd), 0);
    tick();
    chk("wr_issue_cmd", int'(ctrl_cmd), 1);
    chk("wr_issue_addr", int'(sys_addr), 0);
    wcnt = 9'd0;
    tick(); tick();
    chk("wr_held", int'(ctrl_cmd), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("wr_done_cmd", int'(ctrl_cmd), 0);
    chk("wr_done_level", int'(buf_level), 4);
    chk("model_level4", m_level, 4);
    chk("model_wp4", m_wp, 4);

    // stray ack in idle changes nothing
    ack = 1'b1; tick(); ack = 1'b0; tick();
    chk("stray_level", int'(buf_level), 4);
    chk("stray_cmd", int'(ctrl_cmd), 0);

    // second write to reach level 8
    wcnt = 9'd4; tick(); tick();
    chk("wr2_addr", int'(sys_addr), 4);
    wcnt = 9'd0;
    ack = 1'b1; tick(); ack = 1'b0;
    chk("wr2_level", int'(buf_level), 8);

    // read-FIFO space 3 blocks a read, space 6 allows it
    rd_en = 1'b1; rcnt = 9'd253;
    tick(); tick(); tick();
    chk("rd_blocked", int'(ctrl_cmd), 0);
    rcnt = 9'd250;
    tick(); tick();
    chk("rd_issue_cmd", int'(ctrl_cmd), 2);
    chk("rd_issue_addr", int'(sys_addr), 0);
    rd_en = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0;
    chk("rd_done_level", int'(buf_level), 4);

    // both eligible: last op was a read, so write first, then alternate
    wcnt = 9'd40; rd_en = 1'b1; rcnt = 9'd0;
    tick(); tick();
    chk("alt1_cmd", int'(ctrl_cmd), 1);
    chk("alt1_addr", int'(sys_addr), 8);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    chk("alt2_cmd", int'(ctrl_cmd), 2);
    chk("alt2_addr", int'(sys_addr), 4);
    tick();

    // reset in the middle of an outstanding read aborts everything
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_cmd", int'(ctrl_cmd), 0);
    chk("abort_level", int'(buf_level), 0);
    chk("abort_busy", int'(busy), 0);
    rd_en = 1'b0; wcnt = 9'd0;
    tick();

    // randomized traffic: write-heavy, read-heavy, then mixed phases
    for (int i = 0; i < 8000; i++) begin
      int phase;
      phase = i / 2000;
      rst   = ($urandom_range(0, 799) == 0);
      init  = ($urandom_range(0, 19) != 0);
      wcnt  = 9'((phase == 1) ? $urandom_range(0, 5) : $urandom_range(0, 40));
      rd_en = (phase == 0) ? ($urandom_range(0, 9) == 0) :
              (phase == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      rcnt  = 9'((phase >= 2) ? $urandom_range(240, 256) : $urandom_range(0, 256));
      if (m_pend != 0) begin
        if (ack_wait == 0) begin
          ack = 1'b1;
          ack_wait = $urandom_range(0, 5);
        end else begin
          ack = 1'b0;
          ack_wait--;
        end
      end else begin
        ack = ($urandom_range(0, 15) == 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
